// File: rtl/md_share_arbiter.sv
// md_share_arbiter
//   Shares one iterative multiply/divide unit among num_req_p requesters.
//   Requesters are granted round-robin, one operation is in flight at a time,
//   and the unit's result is parked in a local buffer until the issuing
//   requester consumes it.
//
// Ports
//   clk_i, reset_n_i      clock, asynchronous active-low reset
//   req_v_i               per-requester request valid
//   req_opA_i, req_opB_i  packed operands, slice i belongs to requester i
//   req_funct3_i          packed RV32M funct3, slice i belongs to requester i
//   req_ready_o           one-hot grant, combinational in IDLE
//   resp_v_o              one-hot response valid toward the owning requester
//   resp_data_o           buffered result for the asserted resp_v_o bit
//   resp_yumi_i           response consumed (only the owner's bit matters)
//   md_v_o, md_ready_i    issue handshake toward the unit
//   md_opA_o, md_opB_o    operands toward the unit
//   md_funct3_o           funct3 toward the unit
//   md_v_i, md_result_i   result from the unit
//   md_yumi_o             result consumed
//   busy_o                an operation is in flight or awaiting consumption
module md_share_arbiter #(
   parameter int width_p   = 32,
   parameter int num_req_p = 4
) (
   input  logic                           clk_i,
   input  logic                           reset_n_i,
   input  logic [num_req_p-1:0]           req_v_i,
   input  logic [num_req_p*width_p-1:0]   req_opA_i,
   input  logic [num_req_p*width_p-1:0]   req_opB_i,
   input  logic [num_req_p*3-1:0]         req_funct3_i,
   output logic [num_req_p-1:0]           req_ready_o,
   output logic [num_req_p-1:0]           resp_v_o,
   output logic [width_p-1:0]             resp_data_o,
   input  logic [num_req_p-1:0]           resp_yumi_i,
   output logic                           md_v_o,
   input  logic                           md_ready_i,
   output logic [width_p-1:0]             md_opA_o,
   output logic [width_p-1:0]             md_opB_o,
   output logic [2:0]                     md_funct3_o,
   input  logic                           md_v_i,
   input  logic [width_p-1:0]             md_result_i,
   output logic                           md_yumi_o,
   output logic                           busy_o
);

   localparam int lg_req_lp = $clog2(num_req_p);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   state_e                 state_r;
   logic [lg_req_lp-1:0]   last_r;
   logic [lg_req_lp-1:0]   owner_r;
   logic [width_p-1:0]     result_r;

   logic                   grant_en;
   logic [lg_req_lp-1:0]   win;

   // Round-robin pick: the lowest requesting index above `last`, otherwise
   // wrap to the lowest requesting index overall. The second loop overrides
   // the first whenever a candidate above `last` exists.
   function automatic logic [lg_req_lp-1:0] rr_pick(
      input logic [num_req_p-1:0] v,
      input logic [lg_req_lp-1:0] last
   );
      rr_pick = '0;
      for (int i = num_req_p - 1; i >= 0; i--) begin
         if (1'(v >> i)) rr_pick = lg_req_lp'(i);
      end
      for (int i = num_req_p - 1; i >= 0; i--) begin
         if (1'(v >> i) && (lg_req_lp'(i) > last)) rr_pick = lg_req_lp'(i);
      end
   endfunction

   // Grant and issue are combinational so the unit sees the request in the
   // same cycle the winner is chosen. Gating with reset_n_i keeps every
   // output low while reset is held, even with requests pending.
   always_comb begin
      grant_en    = reset_n_i && (state_r == IDLE) && md_ready_i && (|req_v_i);
      win         = rr_pick(req_v_i, last_r);
      req_ready_o = '0;
      md_opA_o    = '0;
      md_opB_o    = '0;
      md_funct3_o = '0;
      if (grant_en) begin
         for (int i = 0; i < num_req_p; i++) begin
            if (win == lg_req_lp'(i)) begin
               req_ready_o[i] = 1'b1;
               md_opA_o       = req_opA_i[i*width_p +: width_p];
               md_opB_o       = req_opB_i[i*width_p +: width_p];
               md_funct3_o    = req_funct3_i[i*3 +: 3];
            end
         end
      end
   end

   assign md_v_o = grant_en;

   // Responses come only from registered state, so md_v_i never reaches
   // resp_v_o combinationally.
   always_comb begin
      resp_v_o    = '0;
      resp_data_o = '0;
      if (state_r == RESP) begin
         for (int i = 0; i < num_req_p; i++) begin
            resp_v_o[i] = (owner_r == lg_req_lp'(i));
         end
         resp_data_o = result_r;
      end
   end

   assign md_yumi_o = (state_r == WAIT) && md_v_i;
   assign busy_o    = (state_r != IDLE);

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r  <= IDLE;
         last_r   <= lg_req_lp'(num_req_p - 1);
         owner_r  <= '0;
         result_r <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (grant_en) begin
                  owner_r <= win;
                  last_r  <= win;
                  state_r <= WAIT;
               end
            end
            WAIT: begin
               if (md_v_i) begin
                  result_r <= md_result_i;
                  state_r  <= RESP;
               end
            end
            RESP: begin
               // Other requesters' yumi bits are ignored.
               if (resp_yumi_i[owner_r]) state_r <= IDLE;
            end
            default: state_r <= IDLE;
         endcase
      end
   end

   // The unit may only present a result while an operation is outstanding.
   a_md_v_only_in_wait: assert property (
      @(posedge clk_i) disable iff (!reset_n_i) md_v_i |-> (state_r == WAIT)
   );

endmodule

// File: tb/tb_md_share_arbiter.sv
module tb_md_share_arbiter;

   localparam int W = 32;
   localparam int N = 4;

   logic            clk_i = 1'b0;
   logic            reset_n_i;
   logic [N-1:0]    req_v_i;
   logic [N*W-1:0]  req_opA_i;
   logic [N*W-1:0]  req_opB_i;
   logic [N*3-1:0]  req_funct3_i;
   logic [N-1:0]    req_ready_o;
   logic [N-1:0]    resp_v_o;
   logic [W-1:0]    resp_data_o;
   logic [N-1:0]    resp_yumi_i;
   logic            md_v_o;
   logic            md_ready_i;
   logic [W-1:0]    md_opA_o;
   logic [W-1:0]    md_opB_o;
   logic [2:0]      md_funct3_o;
   logic            md_v_i;
   logic [W-1:0]    md_result_i;
   logic            md_yumi_o;
   logic            busy_o;

   always #5 clk_i = ~clk_i;

   md_share_arbiter #(.width_p(W), .num_req_p(N)) dut (
      .clk_i        (clk_i),
      .reset_n_i    (reset_n_i),
      .req_v_i      (req_v_i),
      .req_opA_i    (req_opA_i),
      .req_opB_i    (req_opB_i),
      .req_funct3_i (req_funct3_i),
      .req_ready_o  (req_ready_o),
      .resp_v_o     (resp_v_o),
      .resp_data_o  (resp_data_o),
      .resp_yumi_i  (resp_yumi_i),
      .md_v_o       (md_v_o),
      .md_ready_i   (md_ready_i),
      .md_opA_o     (md_opA_o),
      .md_opB_o     (md_opB_o),
      .md_funct3_o  (md_funct3_o),
      .md_v_i       (md_v_i),
      .md_result_i  (md_result_i),
      .md_yumi_o    (md_yumi_o),
      .busy_o       (busy_o)
   );

   int checks = 0;
   int errors = 0;

   // requester operand tables
   logic [31:0] opA [N];
   logic [31:0] opB [N];
   logic [2:0]  f3  [N];

   // unit model and requester behaviour knobs
   bit          unit_busy, pend, force_unready, auto_yumi, drop_on_grant;
   int          unit_lat, u_cnt;
   logic [31:0] u_res;
   int          model_last;

   // observation records
   int           gnt_q[$];
   logic [N-1:0] gv_q[$];
   int           rsp_idx_q[$];
   logic [31:0]  rsp_dat_q[$];
   logic [N-1:0] rv_q[$];
   logic [N-1:0] resp_or;

   // RV32M reference computed with 64-bit arithmetic
   function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb, p;
      logic [63:0] ua, ub, u;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'b0, a};
      ub = {32'b0, b};
      case (f)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * $signed(ub); return p[63:32]; end
         3'd3: begin u = ua * ub; return u[63:32]; end
         3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
         3'd5: begin if (b == 0) return 32'hFFFF_FFFF; u = ua / ub; return u[31:0]; end
         3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
         default: begin if (b == 0) return a; u = ua % ub; return u[31:0]; end
      endcase
   endfunction

   // round-robin reference: first requester after `last`, wrapping
   function automatic int model_pick(input logic [N-1:0] mask, input int last);
      for (int k = 1; k <= N; k++) begin
         int j;
         j = (last + k) % N;
         if (1'(mask >> j)) return j;
      end
      return -1;
   endfunction

   function automatic int idx_of(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (1'(v >> i)) return i;
      return -1;
   endfunction

   task automatic load_ops();
      for (int i = 0; i < N; i++) begin
         req_opA_i[i*W +: W]    = opA[i];
         req_opB_i[i*W +: W]    = opB[i];
         req_funct3_i[i*3 +: 3] = f3[i];
      end
   endtask

   task automatic clear_rec();
      gnt_q.delete(); gv_q.delete(); rsp_idx_q.delete(); rsp_dat_q.delete(); rv_q.delete();
      resp_or = '0;
   endtask

   // One clock: observe handshakes before the edge, then update the unit
   // model and requesters on the following falling edge.
   task automatic step();
      logic fr, fy;
      logic [31:0] a, b;
      logic [2:0] f;
      logic [N-1:0] fg;
      #1;
      fr = md_v_o && md_ready_i;
      a = md_opA_o; b = md_opB_o; f = md_funct3_o;
      fy = md_v_i && md_yumi_o;
      fg = req_ready_o & req_v_i;
      if (req_ready_o != '0) begin
         gnt_q.push_back(idx_of(req_ready_o));
         gv_q.push_back(req_ready_o);
      end
      resp_or |= resp_v_o;
      if ((resp_v_o & resp_yumi_i) != '0) begin
         rsp_idx_q.push_back(idx_of(resp_v_o));
         rsp_dat_q.push_back(resp_data_o);
         rv_q.push_back(resp_v_o);
      end
      @(negedge clk_i);
      if (drop_on_grant) req_v_i = req_v_i & ~fg;
      if (fy) begin md_v_i = 1'b0; unit_busy = 1'b0; end
      if (fr) begin
         unit_busy = 1'b1; pend = 1'b1; u_res = ref_md(f, a, b); u_cnt = unit_lat - 1;
      end else if (pend && u_cnt > 0) begin
         u_cnt--;
      end
      if (pend && u_cnt == 0) begin md_v_i = 1'b1; md_result_i = u_res; pend = 1'b0; end
      if (!md_v_i) md_result_i = $urandom;
      md_ready_i  = !unit_busy && !force_unready;
      resp_yumi_i = auto_yumi ? resp_v_o : '0;
      #1;
   endtask

   task automatic run_until(input int n, input int budget, output bit to, output int steps);
      steps = 0;
      while (rsp_idx_q.size() < n && steps < budget) begin
         step();
         steps++;
      end
      to = (rsp_idx_q.size() < n);
   endtask

   task automatic apply_reset();
      @(negedge clk_i);
      reset_n_i = 1'b0;
      req_v_i = '0; resp_yumi_i = '0; md_v_i = 1'b0;
      pend = 1'b0; unit_busy = 1'b0; force_unready = 1'b0; md_ready_i = 1'b1;
      repeat (2) @(negedge clk_i);
      reset_n_i = 1'b1;
      model_last = N - 1;
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < N; i++) begin opA[i] = $urandom | 1; opB[i] = $urandom; f3[i] = 3'd0; end
      load_ops();
      reset_n_i = 1'b0; req_v_i = 4'b1111; md_ready_i = 1'b1; md_v_i = 1'b0;
      md_result_i = '0; resp_yumi_i = 4'b1111;
      #1;
      checks++;
      if ({req_ready_o, resp_v_o, resp_data_o, md_v_o, md_opA_o, md_opB_o, md_funct3_o, md_yumi_o, busy_o} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got rr=%b rv=%b rd=%h mv=%b a=%h y=%b busy=%b want all 0",
                  req_ready_o, resp_v_o, resp_data_o, md_v_o, md_opA_o, md_yumi_o, busy_o);
      end
      @(negedge clk_i);
      resp_yumi_i = '0;
      reset_n_i = 1'b1;
      #1;
      checks++;
      if (req_ready_o !== 4'b0001) begin
         errors++; $display("FAIL reset_first_grant got %b want 0001", req_ready_o);
      end
      req_v_i = '0;
      #1;
   endtask

   task automatic test_single();
      bit to; int steps;
      apply_reset(); clear_rec();
      opA[0] = 32'd7; opB[0] = 32'hFFFF_FFFD; f3[0] = 3'd0; load_ops();
      unit_lat = 3; auto_yumi = 1'b1; drop_on_grant = 1'b1;
      req_v_i = 4'b0001;
      #1;
      checks++;
      if (req_ready_o !== 4'b0001 || md_v_o !== 1'b1 || md_opA_o !== 32'd7 || md_opB_o !== 32'hFFFF_FFFD) begin
         errors++; $display("FAIL single_issue got rr=%b mv=%b a=%h b=%h want 0001 1 7 fffffffd", req_ready_o, md_v_o, md_opA_o, md_opB_o);
      end
      step();
      checks++;
      if (busy_o !== 1'b1 || req_ready_o !== 4'b0000) begin
         errors++; $display("FAIL single_busy got busy=%b rr=%b want 1 0000", busy_o, req_ready_o);
      end
      run_until(1, 40, to, steps);
      checks++;
      if (to) begin errors++; $display("FAIL single_timeout got no response want 1"); end
      checks++;
      if (gnt_q.size() != 1 || gnt_q[0] != 0) begin
         errors++; $display("FAIL single_grant got %0d grants want one to req0", gnt_q.size());
      end
      checks++;
      if (rv_q.size() == 0 || rv_q[0] !== 4'b0001 || rsp_dat_q[0] !== 32'hFFFF_FFEB) begin
         errors++; $display("FAIL single_resp got v=%b d=%h want 0001 ffffffeb",
                            rv_q.size() ? rv_q[0] : 4'bx, rsp_dat_q.size() ? rsp_dat_q[0] : 32'hx);
      end
      checks++;
      if (steps + 1 != unit_lat + 2) begin
         errors++; $display("FAIL single_latency got %0d cycles want %0d", steps + 1, unit_lat + 2);
      end
      checks++;
      if (busy_o !== 1'b0) begin errors++; $display("FAIL single_busy_drop got %b want 0", busy_o); end
   endtask

   task automatic test_round_robin();
      bit to; int steps; int e;
      apply_reset(); clear_rec();
      for (int i = 0; i < N; i++) begin opA[i] = $urandom; opB[i] = $urandom; f3[i] = 3'($urandom_range(0, 7)); end
      load_ops();
      auto_yumi = 1'b1; drop_on_grant = 1'b0; unit_lat = $urandom_range(1, 4);
      req_v_i = 4'b1111;
      run_until(8, 200, to, steps);
      checks++;
      if (to) begin errors++; $display("FAIL rr_timeout got %0d responses want 8", rsp_idx_q.size()); end
      for (int k = 0; k < 8 && k < gnt_q.size() && k < rsp_idx_q.size(); k++) begin
         e = model_pick(4'b1111, model_last);
         model_last = e;
         checks++;
         if (gnt_q[k] != e || !$onehot(gv_q[k]) || rsp_idx_q[k] != e || rsp_dat_q[k] !== ref_md(f3[e], opA[e], opB[e])) begin
            errors++; $display("FAIL rr_full_%0d got grant %0d resp %0d data %h want %0d data %h",
                               k, gnt_q[k], rsp_idx_q[k], rsp_dat_q[k], e, ref_md(f3[e], opA[e], opB[e]));
         end
      end
      clear_rec();
      req_v_i = 4'b1010;
      run_until(3, 100, to, steps);
      checks++;
      if (to) begin errors++; $display("FAIL rr_sparse_timeout got %0d responses want 3", rsp_idx_q.size()); end
      for (int k = 0; k < 3 && k < gnt_q.size() && k < rsp_idx_q.size(); k++) begin
         e = model_pick(4'b1010, model_last);
         model_last = e;
         checks++;
         if (gnt_q[k] != e || rsp_idx_q[k] != e || rsp_dat_q[k] !== ref_md(f3[e], opA[e], opB[e])) begin
            errors++; $display("FAIL rr_sparse_%0d got grant %0d data %h want %0d data %h",
                               k, gnt_q[k], rsp_dat_q[k], e, ref_md(f3[e], opA[e], opB[e]));
         end
      end
      req_v_i = '0;
   endtask

   task automatic test_divide();
      bit to; int steps; int r; logic [31:0] exp_d;
      // wait out any operation left over from the previous scenario
      while (busy_o) step();
      auto_yumi = 1'b1; drop_on_grant = 1'b1; unit_lat = 4;
      for (int j = 0; j < 9; j++) begin
         clear_rec();
         case (j)
            0: begin r = 1; opA[r] = 32'hFFFF_FFEC; opB[r] = 32'd3; f3[r] = 3'd4; exp_d = 32'hFFFF_FFFA; end
            1: begin r = 2; opA[r] = 32'hFFFF_FFEC; opB[r] = 32'd3; f3[r] = 3'd6; exp_d = 32'hFFFF_FFFE; end
            2: begin r = 3; opA[r] = $urandom;     opB[r] = 32'd0; f3[r] = 3'd5; exp_d = 32'hFFFF_FFFF; end
            default: begin
               r = $urandom_range(0, N - 1);
               opA[r] = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
               case ($urandom_range(0, 3))
                  0: opB[r] = 32'd0;
                  1: opB[r] = 32'hFFFF_FFFF;
                  default: opB[r] = $urandom;
               endcase
               f3[r] = 3'($urandom_range(4, 7));
               exp_d = ref_md(f3[r], opA[r], opB[r]);
            end
         endcase
         load_ops();
         req_v_i = 4'(1 << r);
         run_until(1, 40, to, steps);
         checks++;
         if (to || gnt_q.size() != 1 || gnt_q[0] != r || resp_or !== 4'(1 << r) || rsp_dat_q[0] !== exp_d) begin
            errors++; $display("FAIL div_%0d got grants %0d resp_seen %b data %h want req%0d %b %h",
                               j, gnt_q.size(), resp_or, rsp_dat_q.size() ? rsp_dat_q[0] : 32'hx, r, 4'(1 << r), exp_d);
         end
      end
   endtask

   task automatic test_backpressure();
      int n; logic [31:0] exp0, exp2; bit to; int steps;
      clear_rec();
      auto_yumi = 1'b0; drop_on_grant = 1'b1; unit_lat = 2;
      opA[0] = $urandom; opB[0] = $urandom; f3[0] = 3'd1;
      opA[2] = $urandom; opB[2] = $urandom; f3[2] = 3'd3;
      load_ops();
      exp0 = ref_md(f3[0], opA[0], opB[0]);
      exp2 = ref_md(f3[2], opA[2], opB[2]);
      req_v_i = 4'b0001;
      n = 0;
      while (resp_v_o == '0 && n < 20) begin step(); n++; end
      req_v_i = req_v_i | 4'b0100;
      for (int c = 0; c < 10; c++) begin
         resp_yumi_i = (c % 2) ? 4'b1110 : 4'b0000;
         step();
         checks++;
         if (resp_v_o !== 4'b0001 || resp_data_o !== exp0 || req_ready_o !== 4'b0000 || md_v_o !== 1'b0) begin
            errors++; $display("FAIL bp_hold_%0d got rv=%b rd=%h rr=%b mv=%b want 0001 %h 0000 0",
                               c, resp_v_o, resp_data_o, req_ready_o, md_v_o, exp0);
         end
      end
      resp_yumi_i = 4'b0001;
      #1;
      checks++;
      if (req_ready_o !== 4'b0000) begin errors++; $display("FAIL bp_yumi_cycle got rr=%b want 0000", req_ready_o); end
      step();
      checks++;
      if (resp_v_o !== 4'b0000 || req_ready_o !== 4'b0100 || md_v_o !== 1'b1 || md_opA_o !== opA[2]) begin
         errors++; $display("FAIL bp_next_grant got rv=%b rr=%b mv=%b a=%h want 0000 0100 1 %h",
                            resp_v_o, req_ready_o, md_v_o, md_opA_o, opA[2]);
      end
      auto_yumi = 1'b1;
      run_until(2, 40, to, steps);
      checks++;
      if (to || rsp_idx_q[0] != 0 || rsp_dat_q[0] !== exp0 || rsp_idx_q[1] != 2 || rsp_dat_q[1] !== exp2) begin
         errors++; $display("FAIL bp_results got %0d responses want req0 %h then req2 %h", rsp_idx_q.size(), exp0, exp2);
      end
   endtask

   task automatic test_md_ready();
      bit to; int steps;
      clear_rec();
      auto_yumi = 1'b1; drop_on_grant = 1'b1; unit_lat = 3;
      opA[2] = $urandom; opB[2] = $urandom; f3[2] = 3'd2; load_ops();
      force_unready = 1'b1; md_ready_i = 1'b0;
      req_v_i = 4'b0100;
      #1;
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (req_ready_o !== 4'b0000 || md_v_o !== 1'b0 || md_opA_o !== '0 || md_funct3_o !== '0) begin
            errors++; $display("FAIL unready_%0d got rr=%b mv=%b a=%h want 0000 0 0", c, req_ready_o, md_v_o, md_opA_o);
         end
         step();
      end
      force_unready = 1'b0; md_ready_i = 1'b1;
      #1;
      checks++;
      if (req_ready_o !== 4'b0100 || md_v_o !== 1'b1 || md_opA_o !== opA[2] || md_opB_o !== opB[2] || md_funct3_o !== f3[2]) begin
         errors++; $display("FAIL ready_grant got rr=%b mv=%b a=%h f=%0d want 0100 1 %h %0d",
                            req_ready_o, md_v_o, md_opA_o, md_funct3_o, opA[2], f3[2]);
      end
      run_until(1, 40, to, steps);
      checks++;
      if (to || rsp_idx_q[0] != 2 || rsp_dat_q[0] !== ref_md(f3[2], opA[2], opB[2])) begin
         errors++; $display("FAIL ready_result got %h want %h", rsp_dat_q.size() ? rsp_dat_q[0] : 32'hx, ref_md(f3[2], opA[2], opB[2]));
      end
   endtask

   task automatic test_reset_mid();
      bit to; int steps;
      clear_rec();
      auto_yumi = 1'b1; drop_on_grant = 1'b1; unit_lat = 6;
      opA[0] = 32'h1234_5678; opB[0] = 32'h9; f3[0] = 3'd0; load_ops();
      req_v_i = 4'b0001;
      step(); step();
      checks++;
      if (busy_o !== 1'b1 || resp_v_o !== 4'b0000) begin
         errors++; $display("FAIL midrst_wait got busy=%b rv=%b want 1 0000", busy_o, resp_v_o);
      end
      reset_n_i = 1'b0; req_v_i = 4'b1111; md_ready_i = 1'b1;
      pend = 1'b0; unit_busy = 1'b0; md_v_i = 1'b0;
      #1;
      checks++;
      if ({req_ready_o, resp_v_o, resp_data_o, md_v_o, md_opA_o, md_opB_o, md_funct3_o, md_yumi_o, busy_o} !== '0) begin
         errors++; $display("FAIL midrst_outputs got rr=%b rv=%b mv=%b busy=%b want all 0", req_ready_o, resp_v_o, md_v_o, busy_o);
      end
      repeat (2) @(negedge clk_i);
      opA[0] = 32'h0000_0011; opB[0] = 32'h0000_0005; f3[0] = 3'd0; load_ops();
      reset_n_i = 1'b1;
      #1;
      checks++;
      if (req_ready_o !== 4'b0001) begin errors++; $display("FAIL midrst_first_grant got %b want 0001", req_ready_o); end
      req_v_i = 4'b0001;
      clear_rec();
      run_until(1, 40, to, steps);
      checks++;
      if (to || rsp_idx_q.size() != 1 || rsp_idx_q[0] != 0 || rsp_dat_q[0] !== 32'h0000_0055 || steps != unit_lat + 2) begin
         errors++; $display("FAIL midrst_fresh got n=%0d data=%h cycles=%0d want 1 00000055 %0d",
                            rsp_idx_q.size(), rsp_dat_q.size() ? rsp_dat_q[0] : 32'hx, steps, unit_lat + 2);
      end
   endtask

   initial begin
      reset_n_i = 1'b0; req_v_i = '0; req_opA_i = '0; req_opB_i = '0; req_funct3_i = '0;
      resp_yumi_i = '0; md_ready_i = 1'b1; md_v_i = 1'b0; md_result_i = '0;
      unit_busy = 1'b0; pend = 1'b0; force_unready = 1'b0; auto_yumi = 1'b1; drop_on_grant = 1'b1;
      unit_lat = 1; u_cnt = 0; u_res = '0; model_last = N - 1; resp_or = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_divide();
      test_backpressure();
      test_md_ready();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
